// File: rtl/cnt_mode_arbiter_if.sv
// Job-request and counter-control bundle for cnt_mode_arbiter.
// master = requesters plus counter side, slave = arbiter.
interface cnt_mode_arbiter_if #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
);
  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     req_mode;
  logic [WIDTH*NREQ-1:0] req_init;
  logic [LEN_W*NREQ-1:0] req_len;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  aborted;
  logic                  busy;
  logic                  cnt_gameover;
  logic [1:0]            cnt_control;
  logic                  cnt_INIT;
  logic [WIDTH-1:0]      cnt_initial_value;
  logic                  cnt_clear;

  modport master (
    output req, req_mode, req_init, req_len,
    output cnt_gameover,
    input  gnt, done, aborted, busy,
    input  cnt_control, cnt_INIT,
    input  cnt_initial_value, cnt_clear
  );

  modport slave (
    input  req, req_mode, req_init, req_len,
    input  cnt_gameover,
    output gnt, done, aborted, busy,
    output cnt_control, cnt_INIT,
    output cnt_initial_value, cnt_clear
  );
endinterface

// File: rtl/cnt_mode_arbiter.sv
// Shares one up/down counter among NREQ job requesters (round robin).
// CNT_ARB_FIXED_PRIO_EN: lowest-index pending requester always wins.
module cnt_mode_arbiter #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  cnt_mode_arbiter_if.slave bus
);

  localparam int OW = (NREQ > 2) ? 2 : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_ABORT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_nxt;
  logic [OW-1:0]    r_owner;
  logic [OW-1:0]    r_last;
  logic [1:0]       r_mode;
  logic [WIDTH-1:0] r_init;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_rem;
  logic             r_abort;

  logic             w_any;
  logic [OW-1:0]    w_win;
  int               w_idx;

  logic [NREQ-1:0]  w_gnt;
  logic [NREQ-1:0]  w_done;
  logic             w_aborted;
  logic             w_busy;
  logic [1:0]       w_ctrl;
  logic             w_init_en;
  logic [WIDTH-1:0] w_init_val;
  logic             w_clear;

  // Scan downward so the last hit is the highest-priority candidate.
  always_comb begin
    w_any = |bus.req;
    w_win = '0;
    w_idx = 0;
`ifdef CNT_ARB_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_idx = i;
      if (bus.req[w_idx]) w_win = OW'(w_idx);
    end
`else
    for (int i = NREQ; i >= 1; i--) begin
      w_idx = (int'(r_last) + i) % NREQ;
      if (bus.req[w_idx]) w_win = OW'(w_idx);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  // Gameover wins over length expiry in the same RUN cycle.
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any) w_nxt = S_LOAD;
      S_LOAD:  w_nxt = S_RUN;
      S_RUN: begin
        if (bus.cnt_gameover)        w_nxt = S_ABORT;
        else if (r_rem == LEN_W'(1)) w_nxt = S_DONE;
      end
      S_ABORT: w_nxt = S_DONE;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= '0;
      r_last  <= OW'(NREQ - 1);
      r_mode  <= '0;
      r_init  <= '0;
      r_len   <= '0;
      r_rem   <= '0;
      r_abort <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner <= w_win;
            r_mode  <= bus.req_mode[int'(w_win)*2 +: 2];
            r_init  <= bus.req_init[int'(w_win)*WIDTH +: WIDTH];
            r_len   <= bus.req_len[int'(w_win)*LEN_W +: LEN_W];
          end
        end
        S_LOAD: begin
          r_rem <= (r_len == '0) ? LEN_W'(1) : r_len;
        end
        S_RUN: begin
          if (bus.cnt_gameover) r_abort <= 1'b1;
          else                  r_rem   <= r_rem - LEN_W'(1);
        end
        S_DONE: begin
          r_last  <= r_owner;
          r_abort <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from state and captured job flops only.
  always_comb begin
    w_gnt      = '0;
    w_done     = '0;
    w_aborted  = 1'b0;
    w_busy     = (r_state != S_IDLE);
    w_ctrl     = r_mode;
    w_init_en  = 1'b0;
    w_init_val = '0;
    w_clear    = 1'b0;
    unique case (r_state)
      S_LOAD: begin
        w_gnt[r_owner] = 1'b1;
        w_init_en      = 1'b1;
        w_init_val     = r_init;
      end
      S_ABORT: w_clear = 1'b1;
      S_DONE: begin
        w_done[r_owner] = 1'b1;
        w_aborted       = r_abort;
      end
      default: ;
    endcase
  end

  assign bus.gnt               = w_gnt;
  assign bus.done              = w_done;
  assign bus.aborted           = w_aborted;
  assign bus.busy              = w_busy;
  assign bus.cnt_control       = w_ctrl;
  assign bus.cnt_INIT          = w_init_en;
  assign bus.cnt_initial_value = w_init_val;
  assign bus.cnt_clear         = w_clear;

endmodule
